// File: rtl/sprite_mover_pkg.sv
// Shared types and constants for the bouncing sprite mover.
package sprite_mover_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StDraw,
        StWait,
        StErase,
        StMove
    } state_e;

    localparam logic [2:0]  ERASE_COLOUR     = 3'b000;
    localparam int unsigned SCREEN_W_DEFAULT = 160;
    localparam int unsigned SCREEN_H_DEFAULT = 120;

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? b : a;
    endfunction

endpackage

// File: rtl/sprite_mover_frame_timer.sv
// Frame tick divider plus frame counter; pulses move_due on the last tick of a move period.
module frame_timer #(
    parameter int unsigned TICKS_PER_FRAME = 833333,
    parameter int unsigned FRAMES_PER_MOVE = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic reload,
    input  logic enable,
    output logic move_due
);

    localparam int unsigned TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int unsigned FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [TW-1:0] TICK_LOAD  = TW'(TICKS_PER_FRAME - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          frame_tick;

    assign frame_tick = enable && (tick_q == '0);
    assign move_due   = frame_tick && (frame_q == FRAME_LAST);

    always_comb begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (reload) begin
            tick_d  = TICK_LOAD;
            frame_d = '0;
        end else if (enable) begin
            if (frame_tick) begin
                tick_d  = TICK_LOAD;
                frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
            end else begin
                tick_d = tick_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_q  <= TICK_LOAD;
            frame_q <= '0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Draws a SPRITE_W x SPRITE_H block, waits a move period, erases it and steps it,
// bouncing off the screen edges.
module sprite_mover
    import sprite_mover_pkg::*;
#(
    parameter int unsigned SPRITE_W        = 4,
    parameter int unsigned SPRITE_H        = 4,
    parameter int unsigned SCREEN_W        = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H        = SCREEN_H_DEFAULT,
    parameter int unsigned TICKS_PER_FRAME = 833333,
    parameter int unsigned FRAMES_PER_MOVE = 15,
    parameter int unsigned STEP            = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_init,
    input  logic [6:0] y_init,
    input  logic       dir_x_init,
    input  logic       dir_y_init,
    input  logic [2:0] colour_in,
    input  logic       pause,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic       busy,
    output logic       move_pulse
);

    localparam logic [3:0] COL_LAST = 4'(SPRITE_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(SPRITE_H - 1);
    localparam logic [8:0] STEP9    = 9'(STEP);
    localparam logic [8:0] W9       = 9'(SPRITE_W);
    localparam logic [8:0] H9       = 9'(SPRITE_H);
    localparam logic [8:0] SCR_W9   = 9'(SCREEN_W);
    localparam logic [8:0] SCR_H9   = 9'(SCREEN_H);

    state_e     state_q, state_d;
    logic [7:0] pos_x_q, pos_x_d;
    logic [6:0] pos_y_q, pos_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;

    logic       timer_reload, timer_enable, move_due;
    logic [8:0] px9, py9, mx9, my9;
    logic       mdx, mdy;
    logic       last_pix;

    frame_timer #(
        .TICKS_PER_FRAME(TICKS_PER_FRAME),
        .FRAMES_PER_MOVE(FRAMES_PER_MOVE)
    ) u_frame_timer (
        .clock   (clock),
        .resetn  (resetn),
        .reload  (timer_reload),
        .enable  (timer_enable),
        .move_due(move_due)
    );

    assign px9      = {1'b0, pos_x_q};
    assign py9      = {2'b00, pos_y_q};
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // 9-bit step/bounce so the right/bottom compare cannot wrap
    always_comb begin
        if (dir_x_q) begin
            if (px9 + STEP9 + W9 <= SCR_W9) begin
                mx9 = px9 + STEP9;
                mdx = 1'b1;
            end else begin
                mx9 = px9 - STEP9;
                mdx = 1'b0;
            end
        end else if (px9 >= STEP9) begin
            mx9 = px9 - STEP9;
            mdx = 1'b0;
        end else begin
            mx9 = px9 + STEP9;
            mdx = 1'b1;
        end

        if (dir_y_q) begin
            if (py9 + STEP9 + H9 <= SCR_H9) begin
                my9 = py9 + STEP9;
                mdy = 1'b1;
            end else begin
                my9 = py9 - STEP9;
                mdy = 1'b0;
            end
        end else if (py9 >= STEP9) begin
            my9 = py9 - STEP9;
            mdy = 1'b0;
        end else begin
            my9 = py9 + STEP9;
            mdy = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        col_d        = col_q;
        row_d        = row_q;
        timer_reload = (state_q != StWait);
        timer_enable = (state_q == StWait) && !pause;

        case (state_q)
            StIdle: begin
                if (start) begin
                    pos_x_d = 8'(min9({1'b0, x_init}, SCR_W9 - W9));
                    pos_y_d = 7'(min9({2'b00, y_init}, SCR_H9 - H9));
                    dir_x_d = dir_x_init;
                    dir_y_d = dir_y_init;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!start) state_d = StDraw;
            end
            StDraw, StErase: begin
                if (last_pix) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (state_q == StDraw) ? StWait : StMove;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StWait: begin
                if (move_due) state_d = StErase;
            end
            StMove: begin
                pos_x_d = mx9[7:0];
                pos_y_d = my9[6:0];
                dir_x_d = mdx;
                dir_y_d = mdy;
                state_d = StDraw;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            pos_x_q <= '0;
            pos_y_q <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        plot       = (state_q == StDraw) || (state_q == StErase);
        x_out      = '0;
        y_out      = '0;
        colour_out = '0;
        if (plot) begin
            x_out      = pos_x_q + {4'b0000, col_q};
            y_out      = pos_y_q + {3'b000, row_q};
            colour_out = (state_q == StDraw) ? colour_in : ERASE_COLOUR;
        end
        busy       = (state_q != StIdle);
        move_pulse = (state_q == StMove);
        pos_x      = pos_x_q;
        pos_y      = pos_y_q;
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: stimulus queues expected pixels/moves, a monitor checks them.
module tb_sprite_mover;

    localparam int SW = 4;
    localparam int SH = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_init = '0;
    logic [6:0] y_init = '0;
    logic       dir_x_init = 1'b1;
    logic       dir_y_init = 1'b1;
    logic [2:0] colour_in = '0;
    logic       pause = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       busy;
    logic       move_pulse;

    always #5 clock = ~clock;

    sprite_mover #(
        .SPRITE_W       (SW),
        .SPRITE_H       (SH),
        .SCREEN_W       (160),
        .SCREEN_H       (120),
        .TICKS_PER_FRAME(4),
        .FRAMES_PER_MOVE(2),
        .STEP           (1)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .x_init    (x_init),
        .y_init    (y_init),
        .dir_x_init(dir_x_init),
        .dir_y_init(dir_y_init),
        .colour_in (colour_in),
        .pause     (pause),
        .x_out     (x_out),
        .y_out     (y_out),
        .colour_out(colour_out),
        .plot      (plot),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .move_pulse(move_pulse)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } pos_t;

    pix_t pq[$];
    pos_t mq[$];
    pix_t ep;
    pos_t em;
    logic move_seen = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void check(string name, int actual, int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endfunction

    function automatic void report_fail(string name, string detail);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, detail);
    endfunction

    // Monitor: every plot cycle and every post-move position is checked against the queues.
    always @(negedge clock) begin
        if (!resetn) begin
            move_seen <= 1'b0;
        end else begin
            if (plot) begin
                if (pq.size() == 0) begin
                    report_fail("spurious_plot",
                                $sformatf("plot at (%0d,%0d) with nothing expected", x_out, y_out));
                end else begin
                    ep = pq.pop_front();
                    check("plot_x", int'(x_out), int'(ep.x));
                    check("plot_y", int'(y_out), int'(ep.y));
                    check("plot_colour", int'(colour_out), int'(ep.c));
                end
            end
            if (move_seen) begin
                if (mq.size() == 0) begin
                    report_fail("spurious_move", $sformatf("moved to (%0d,%0d)", pos_x, pos_y));
                end else begin
                    em = mq.pop_front();
                    check("move_pos_x", int'(pos_x), int'(em.x));
                    check("move_pos_y", int'(pos_y), int'(em.y));
                end
            end
            move_seen <= move_pulse;
        end
    end

    task automatic push_rect(input int x, input int y, input int c);
        pix_t p;
        for (int r = 0; r < SH; r++) begin
            for (int k = 0; k < SW; k++) begin
                p.x = 8'(x + k);
                p.y = 7'(y + r);
                p.c = 3'(c);
                pq.push_back(p);
            end
        end
    endtask

    task automatic push_move(input int x, input int y);
        pos_t p;
        p.x = 8'(x);
        p.y = 7'(y);
        mq.push_back(p);
    endtask

    task automatic launch(input int x, input int y, input bit dx, input bit dy, input int c);
        @(negedge clock);
        x_init     = 8'(x);
        y_init     = 7'(y);
        dir_x_init = dx;
        dir_y_init = dy;
        colour_in  = 3'(c);
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_plot(input bit level, input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (plot !== level && k < budget);
        if (plot !== level) report_fail(name, "timed out waiting for plot level");
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while ((pq.size() != 0 || mq.size() != 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (pq.size() != 0 || mq.size() != 0)
            report_fail(name, $sformatf("%0d pixels and %0d moves never seen", pq.size(),
                                        mq.size()));
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        pq.delete();
        mq.delete();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Counts unpaused WAIT cycles from draw end to erase start; pause applied on cycles
    // [pause_from, pause_from+pause_len).
    task automatic measure_gap(input int pause_from, input int pause_len, output int gap);
        int k;
        wait_plot(1'b0, 100, "draw_end_timeout");
        gap = 0;
        k   = 0;
        while (!plot && k < 200) begin
            pause = (k >= pause_from) && (k < pause_from + pause_len);
            if (!pause) gap++;
            k++;
            @(negedge clock);
        end
        pause = 1'b0;
    endtask

    int gap;

    initial begin
        // Reset state
        @(negedge clock);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_move_pulse", int'(move_pulse), 0);
        check("rst_x_out", int'(x_out), 0);
        check("rst_y_out", int'(y_out), 0);
        check("rst_colour", int'(colour_out), 0);
        check("rst_pos_x", int'(pos_x), 0);
        check("rst_pos_y", int'(pos_y), 0);
        resetn = 1'b1;

        // Launch, draw, move cadence and redraw
        push_rect(10, 20, 5);
        push_rect(10, 20, 0);
        push_move(11, 21);
        push_rect(11, 21, 5);
        launch(10, 20, 1'b1, 1'b1, 5);
        wait_plot(1'b1, 10, "draw_start_timeout");
        check("busy_running", int'(busy), 1);
        measure_gap(1000, 0, gap);
        check("wait_cycles", gap, 8);
        wait_drain(200, "cadence_drain");
        do_reset();

        // Right-edge bounce, second move proves the direction flipped
        push_rect(156, 20, 2);
        push_rect(156, 20, 0);
        push_move(155, 21);
        push_rect(155, 21, 2);
        push_rect(155, 21, 0);
        push_move(154, 22);
        push_rect(154, 22, 2);
        launch(156, 20, 1'b1, 1'b1, 2);
        wait_drain(300, "right_bounce_drain");
        do_reset();

        // Left/top bounce from the origin moving up-left
        push_rect(0, 0, 7);
        push_rect(0, 0, 0);
        push_move(1, 1);
        push_rect(1, 1, 7);
        push_rect(1, 1, 0);
        push_move(2, 2);
        push_rect(2, 2, 7);
        launch(0, 0, 1'b0, 1'b0, 7);
        wait_drain(300, "left_bounce_drain");
        do_reset();

        // Out-of-range start clamps to the last legal position
        push_rect(156, 116, 1);
        launch(200, 127, 1'b1, 1'b1, 1);
        wait_drain(50, "clamp_drain");
        check("clamp_pos_x", int'(pos_x), 156);
        check("clamp_pos_y", int'(pos_y), 116);
        do_reset();

        // Pause during WAIT freezes the move period
        push_rect(30, 40, 3);
        push_rect(30, 40, 0);
        push_move(31, 41);
        push_rect(31, 41, 3);
        launch(30, 40, 1'b1, 1'b1, 3);
        wait_plot(1'b1, 10, "pause_draw_timeout");
        measure_gap(3, 20, gap);
        check("paused_wait_cycles", gap, 8);
        wait_drain(200, "pause_drain");
        do_reset();

        // Reset at the 7th DRAW pixel
        push_rect(50, 60, 4);
        launch(50, 60, 1'b1, 1'b1, 4);
        wait_plot(1'b1, 10, "rst_draw_timeout");
        repeat (6) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_plot", int'(plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_x_out", int'(x_out), 0);
        check("midrst_pos_x", int'(pos_x), 0);
        check("midrst_pos_y", int'(pos_y), 0);
        check("midrst_pixels_left", pq.size(), 10);
        pq.delete();
        mq.delete();
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_plot", int'(plot), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
